// File: rtl/cond_logic_pkg.sv
// Purpose: condition-code and flag-index constants shared by cond_logic, the ALU and the decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cond_logic_pkg;

  // ARM condition field encodings, Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_check.sv
// Purpose: evaluates a 4-bit ARM condition field against the stored NZCV flags.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   Cond   in  4  condition field
//   Flags  in  4  registered {N,Z,C,V}
//   CondEx out 1  condition passed
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  always_comb begin
    n = Flags[FLAG_N];
    z = Flags[FLAG_Z];
    c = Flags[FLAG_C];
    v = Flags[FLAG_V];
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      // 4'hF is treated as unconditional
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Purpose: NZCV flag register, latched condition-passed bit and gating of controller write strobes.
// Latency: CondExR valid 1 cycle after CondLatch; flags update on the edge after the write request.
// Backpressure: none; all strobes are level signals with no handshake.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   Cond, ALUFlags, FlagW      condition field, ALU {N,Z,C,V}, flag write request {NZ,CV}
//   CondLatch                  samples the condition result (Decode)
//   PCS, NextPC, RegW, MemW    controller write requests
//   PCWrite, RegWrite, MemWrite gated write enables
//   CondExR, Flags             latched condition bit, architectural flags
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondExR,
  output logic [3:0] Flags
);

  logic cond_ex;

  // Evaluated from the registered flags only, so a flag write on the
  // same edge as CondLatch never forwards into the condition result.
  cond_check u_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags   <= FLAG_RESET;
      CondExR <= 1'b0;
    end else begin
      // Cond is only looked at when CondLatch is high, so X on Cond
      // outside Decode cannot reach any state.
      if (CondLatch) begin
        CondExR <= cond_ex;
      end
      // Flag writes are gated by the CondExR value held before this edge.
      if (FlagW[1] && CondExR) begin
        Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (FlagW[0] && CondExR) begin
        Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  // CondExR clears asynchronously, so these drop as soon as reset rises.
  assign PCWrite  = (PCS & CondExR) | NextPC;
  assign RegWrite = RegW & CondExR;
  assign MemWrite = MemW & CondExR;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondExR;
  logic [3:0] Flags;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [3:0] m_flags;
  logic       m_cex;

  cond_logic #(.FLAG_RESET(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .CondLatch (CondLatch),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .CondExR   (CondExR),
    .Flags     (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Odd codes below 14 are the negation of the even code before them.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    logic [2:0] grp;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c >= 4'hE) return 1'b1;
    grp = c[3:1];
    case (grp)
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_flags"}, Flags, m_flags);
    chk({tag, "_cex"}, {3'b0, CondExR}, {3'b0, m_cex});
    chk({tag, "_pcw"}, {3'b0, PCWrite}, {3'b0, (PCS & m_cex) | NextPC});
    chk({tag, "_regw"}, {3'b0, RegWrite}, {3'b0, RegW & m_cex});
    chk({tag, "_memw"}, {3'b0, MemWrite}, {3'b0, MemW & m_cex});
  endtask

  task automatic set_in(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                        input logic lat, input logic pcs_i, input logic npc,
                        input logic rw, input logic mw);
    Cond = c; ALUFlags = af; FlagW = fw; CondLatch = lat;
    PCS = pcs_i; NextPC = npc; RegW = rw; MemW = mw;
  endtask

  // One rising edge; inputs are stable here because they change 1 time unit after the edge.
  task automatic tick(input string tag);
    logic [3:0] nf;
    logic       nc;
    @(posedge clk);
    nf = m_flags;
    nc = m_cex;
    if (CondLatch === 1'b1) nc = cond_model(Cond, m_flags);
    if (FlagW[1] && m_cex) nf[3:2] = ALUFlags[3:2];
    if (FlagW[0] && m_cex) nf[1:0] = ALUFlags[1:0];
    m_flags = nf;
    m_cex   = nc;
    #1;
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1;
    set_in(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    m_flags = 4'b0000;
    m_cex   = 1'b0;
    #2;
    // reset state
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_cex", {3'b0, CondExR}, 4'h0);
    chk("rst_regw", {3'b0, RegWrite}, 4'h0);
    chk("rst_memw", {3'b0, MemWrite}, 4'h0);
    chk("rst_pcw", {3'b0, PCWrite}, 4'h1);
    @(posedge clk); #2;
    reset = 1'b0;

    // EQ with Z=0 fails
    set_in(4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick("eq_fail");
    chk("eq_fail_cex", {3'b0, CondExR}, 4'h0);
    chk("eq_fail_regw", {3'b0, RegWrite}, 4'h0);
    chk("eq_fail_pcw", {3'b0, PCWrite}, 4'h1);

    // AL latch, then write Z, then EQ passes
    set_in(4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("al_latch");
    set_in(4'h0, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("wr_z");
    chk("wr_z_flags", Flags, 4'b0100);
    set_in(4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("eq_pass");
    chk("eq_pass_cex", {3'b0, CondExR}, 4'h1);
    chk("eq_pass_regw", {3'b0, RegWrite}, 4'h1);

    // N=1,V=0: GE fails and blocks flag writes and MemWrite
    set_in(4'h0, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("wr_n");
    set_in(4'hA, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ge_latch");
    chk("ge_cex", {3'b0, CondExR}, 4'h0);
    set_in(4'h0, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("ge_blocked");
    chk("ge_blocked_flags", Flags, 4'b1000);
    chk("ge_blocked_memw", {3'b0, MemWrite}, 4'h0);

    // Partial writes: NZ only, then CV only
    set_in(4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("al_latch2");
    set_in(4'h0, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("clr_flags");
    set_in(4'h0, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("wr_nz");
    chk("wr_nz_flags", Flags, 4'b1100);
    set_in(4'h0, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("wr_cv");
    chk("wr_cv_flags", Flags, 4'b1111);

    // Same edge: failing latch plus flag write; write uses old CondExR=1,
    // condition uses pre-update flags (Z=1 so NE fails).
    set_in(4'h1, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("same_edge");
    chk("same_edge_flags", Flags, 4'b0000);
    chk("same_edge_cex", {3'b0, CondExR}, 4'h0);

    // Sweep all conditions over all flag values
    for (int f = 0; f < 16; f++) begin
      set_in(4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("sw_al");
      set_in(4'h0, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("sw_wr");
      for (int c = 0; c < 16; c++) begin
        set_in(4'(c), 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick("sweep");
        if (f == 2 && c == 8) chk("hi_0010", {3'b0, CondExR}, 4'h1);
        if (f == 2 && c == 9) chk("ls_0010", {3'b0, CondExR}, 4'h0);
        if (f == 9 && c == 12) chk("gt_1001", {3'b0, CondExR}, 4'h1);
        if (f == 9 && c == 13) chk("le_1001", {3'b0, CondExR}, 4'h0);
      end
    end

    // Random traffic, with X on Cond whenever it is not being latched
    for (int i = 0; i < 400; i++) begin
      logic lat;
      lat = 1'($urandom_range(0, 1));
      set_in(4'($urandom), 4'($urandom), 2'($urandom), lat,
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (!lat && $urandom_range(0, 1) == 1) Cond = 4'bxxxx;
      tick("rand");
    end

    // Mid-cycle reset with CondExR=1 and strobes requested
    set_in(4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("pre_rst_al");
    set_in(4'h0, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("pre_rst_wr");
    CondLatch = 1'b0; FlagW = 2'b00;
    #2;
    chk("pre_rst_regw", {3'b0, RegWrite}, 4'h1);
    chk("pre_rst_pcw", {3'b0, PCWrite}, 4'h1);
    reset = 1'b1;
    #1;
    m_flags = 4'b0000;
    m_cex   = 1'b0;
    chk("mid_rst_regw", {3'b0, RegWrite}, 4'h0);
    chk("mid_rst_pcw", {3'b0, PCWrite}, 4'h0);
    chk("mid_rst_flags", Flags, 4'b0000);
    chk("mid_rst_cex", {3'b0, CondExR}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    tick("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Sits directly downstream of the ALU in the multi-cycle ARM datapath.
- Holds the architectural NZCV flag register, written from the ALU's 4-bit ALUFlags {N,Z,C,V}.
- Evaluates the instruction's 4-bit condition field against the stored flags and latches the resulting CondEx once per instruction.
- Uses that latched bit to gate the controller's write strobes (PCWrite, RegWrite, MemWrite) and its own flag updates.

Parameters:
- FLAG_RESET, 4'b0000, value loaded into Flags {N,Z,C,V} on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current operation.
- FlagW  in  2  flag write request: [1] writes N,Z; [0] writes C,V.
- CondLatch  in  1  controller strobe, asserted for one cycle in the Decode state; samples the condition result.
- PCS  in  1  instruction writes the PC (branch or Rd=PC).
- NextPC  in  1  unconditional PC write (Fetch / PC increment).
- RegW  in  1  controller register-write request.
- MemW  in  1  controller memory-write request.
- PCWrite  out  1  gated PC write enable.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated memory write enable.
- CondExR  out  1  latched condition-passed bit.
- Flags  out  4  current architectural {N,Z,C,V}.

Behaviour:
- Reset (asynchronous, no clock needed): Flags=FLAG_RESET and CondExR=0.
  - During reset: RegWrite=0, MemWrite=0, PCWrite=NextPC.
- Condition evaluation is combinational, from Cond and the registered Flags only, never from ALUFlags:
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1 (unconditional)
- CondExR: loaded with the evaluated condition at the clock edge where CondLatch=1; holds its value otherwise.
  - Latency: 1 cycle from CondLatch to a valid CondExR.
- Flag update at each rising edge:
  - if FlagW[1]&CondExR, Flags[3:2]<=ALUFlags[3:2];
  - if FlagW[0]&CondExR, Flags[1:0]<=ALUFlags[1:0].
  - The two halves are independent; partial writes are legal (e.g. a logical op with shift writes NZ only).
- Gated outputs, combinational from the registered CondExR:
  - PCWrite=(PCS&CondExR)|NextPC
  - RegWrite=RegW&CondExR
  - MemWrite=MemW&CondExR
- CondLatch and FlagW active on the same edge: CondExR takes the condition evaluated from the pre-update Flags; the flag write is gated by the old CondExR. No forwarding from ALUFlags.
- Failed condition (CondExR=0): Flags are unchanged regardless of FlagW; RegWrite=MemWrite=0; PCWrite follows NextPC only.
- Reset asserted mid-instruction: state is cleared immediately and all gated strobes except NextPC drop in the same cycle.
- X on Cond while CondLatch=0 must not affect any state.

Decomposition:
- Shared package holds:
  - condition-code constants COND_EQ..COND_AL;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - these are shared with the ALU and decoder.
- One combinational sub-module, cond_check (Cond, Flags -> CondEx), which holds the 16-entry table above.
- The flag registers, the CondExR register and the output gating stay in cond_logic.

Test Plan:
- Reset with FLAG_RESET=4'b0000, then CondLatch with Cond=4'h0 (EQ) -> CondExR=0; RegW=1 gives RegWrite=0; NextPC=1 gives PCWrite=1.
- Cond=4'hE latched, FlagW=2'b11, ALUFlags=4'b0100 -> next cycle Flags=4'b0100; then latch Cond=4'h0 -> CondExR=1 and RegW=1 gives RegWrite=1.
- Flags=4'b1000, latch Cond=4'hA (GE) -> CondExR=0; then FlagW=2'b11, ALUFlags=4'b0110 -> Flags stay 4'b1000, MemW=1 gives MemWrite=0.
- Flags=4'b0000, CondExR=1, FlagW=2'b10, ALUFlags=4'b1111 -> Flags=4'b1100 (C,V untouched); then FlagW=2'b01, ALUFlags=4'b0011 -> Flags=4'b1111.
- Sweep all 16 Cond values over all 16 Flags values -> CondExR matches the table; specifically Flags=4'b0010 gives HI=1, LS=0; Flags=4'b1001 gives GT=1, LE=0.
- Assert reset mid-cycle with CondExR=1, RegW=1, PCS=1, NextPC=0 -> RegWrite and PCWrite fall immediately; Flags=FLAG_RESET before the next clock edge.
